// File: rtl/vec_load_unit_pkg.sv
// vec_load_unit_pkg: shared state encoding, default geometry and lane-count helper for vec_load_unit
package vec_load_unit_pkg;
    localparam int S = 32;
    localparam int V = 192;
    localparam int LANES = V / S;
    localparam int SIZE = 30015;
    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
    function automatic logic [2:0] eff_count(input logic [2:0] c, input int lanes);
        return (c == 3'd0 || int'(c) > lanes) ? 3'(lanes) : c;
    endfunction
endpackage

// File: rtl/vec_lane_reg.sv
// vec_lane_reg: lanes x S-bit result register; clk/reset async clear, clr sync clear, we per-lane write of wdata, q packed lanes
module vec_lane_reg
    import vec_load_unit_pkg::*;
#(
    parameter int S = 32,
    parameter int LANES = 6
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic [LANES-1:0]   we,
    input  logic [S-1:0]       wdata,
    output logic [S*LANES-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else if (clr) q <= '0;
        else
            for (int i = 0; i < LANES; i++)
                if (we[i]) q[i*S +: S] <= wdata;
    end
endmodule

// File: rtl/vec_load_unit.sv
// vec_load_unit: gathers count ROM words from base_addr into vec_out; start/base_addr/count request, rom_addr/rom_rd ROM port, vec_out/vec_valid/vec_ready result handshake, busy and sticky err status
module vec_load_unit
    import vec_load_unit_pkg::*;
#(
    parameter int S = 32,
    parameter int V = 192,
    parameter int SIZE = 30015
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [S-1:0] base_addr,
    input  logic [2:0]   count,
    output logic [S-1:0] rom_addr,
    input  logic [V-1:0] rom_rd,
    output logic [V-1:0] vec_out,
    output logic         vec_valid,
    input  logic         vec_ready,
    output logic         busy,
    output logic         err
);
    localparam int n_lanes = V / S;
    state_t state, state_nxt;
    logic [S-1:0] base, addr;
    logic [2:0] idx, n;
    logic oor, clr, unused_rd;
    logic [n_lanes-1:0] we;
    assign unused_rd = ^rom_rd[V-1:S];
    assign addr = base + S'(idx);
    assign oor = addr >= S'(SIZE);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state == IDLE  ? (start ? FETCH : IDLE) :
                    state == FETCH ? (idx == n - 3'd1 ? DONE : FETCH) :
                                     (vec_ready ? IDLE : DONE);
    end
    always_comb begin
        busy = state != IDLE;
        vec_valid = state == DONE;
        rom_addr = state == FETCH ? addr : base;
        clr = state == IDLE && start;
        we = state == FETCH ? n_lanes'(1) << idx : '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base <= '0;
            n <= 3'(n_lanes);
            idx <= '0;
            err <= 1'b0;
        end else if (clr) begin
            base <= base_addr;
            n <= eff_count(count, n_lanes);
            idx <= '0;
            err <= 1'b0;
        end else if (state == FETCH) begin
            idx <= idx + 3'd1;
            err <= err | oor;
        end
    end
    // out-of-range addresses load zero instead of whatever the ROM returns
    vec_lane_reg #(.S(S), .LANES(n_lanes)) u_lanes (
        .clk(clk),
        .reset(reset),
        .clr(clr),
        .we(we),
        .wdata(oor ? '0 : rom_rd[S-1:0]),
        .q(vec_out)
    );
endmodule

// File: tb/tb_vec_load_unit.sv
// tb_vec_load_unit: randomized and directed checks of vec_load_unit against a lane-list reference model
module tb_vec_load_unit;
    localparam int S = 32;
    localparam int V = 192;
    localparam int SIZE = 30015;
    localparam int LANES = 6;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [S-1:0] base_addr = '0;
    logic [2:0] count = '0;
    logic [S-1:0] rom_addr;
    logic [V-1:0] rom_rd;
    logic [V-1:0] vec_out;
    logic vec_valid;
    logic vec_ready = 1'b0;
    logic busy, err;
    logic [V-S-1:0] junk = '0;
    logic [S-1:0] seen_addr[$];
    int nchecks = 0;
    int nerr = 0;

    vec_load_unit #(.S(S), .V(V), .SIZE(SIZE)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
        .rom_addr(rom_addr), .rom_rd(rom_rd), .vec_out(vec_out), .vec_valid(vec_valid),
        .vec_ready(vec_ready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(negedge clk) junk = {$urandom, $urandom, $urandom, $urandom, $urandom};
    always_comb rom_rd = {junk, rom_addr + 32'd100};

    function automatic int model_n(input int c);
        return (c == 0 || c > LANES) ? LANES : c;
    endfunction

    function automatic logic [V-1:0] model_vec(input logic [S-1:0] b, input int c);
        logic [V-1:0] r = '0;
        logic [S-1:0] a;
        for (int i = 0; i < model_n(c); i++) begin
            a = b + S'(i);
            if (a < S'(SIZE)) r[i*S +: S] = a + 32'd100;
        end
        return r;
    endfunction

    function automatic logic model_err(input logic [S-1:0] b, input int c);
        logic e = 1'b0;
        logic [S-1:0] a;
        for (int i = 0; i < model_n(c); i++) begin
            a = b + S'(i);
            if (a >= S'(SIZE)) e = 1'b1;
        end
        return e;
    endfunction

    task automatic run_load(input logic [S-1:0] b, input logic [2:0] c, output int lat,
                            output logic [V-1:0] v, output logic e);
        seen_addr.delete();
        start = 1'b1;
        base_addr = b;
        count = c;
        @(negedge clk);
        start = 1'b0;
        base_addr = $urandom;
        count = 3'($urandom);
        lat = 1;
        while (!vec_valid && lat < 20) begin
            if (busy) seen_addr.push_back(rom_addr);
            @(negedge clk);
            lat++;
        end
        v = vec_out;
        e = err;
    endtask

    task automatic finish_load();
        vec_ready = 1'b1;
        @(negedge clk);
        vec_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        nchecks++; if (vec_out !== '0) begin nerr++; $display("FAIL reset vec_out: got %h expected 0", vec_out); end
        nchecks++; if (vec_valid !== 1'b0) begin nerr++; $display("FAIL reset vec_valid: got %b expected 0", vec_valid); end
        nchecks++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset busy: got %b expected 0", busy); end
        nchecks++; if (err !== 1'b0) begin nerr++; $display("FAIL reset err: got %b expected 0", err); end
        nchecks++; if (rom_addr !== '0) begin nerr++; $display("FAIL reset rom_addr: got %h expected 0", rom_addr); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [S-1:0] bases[4] = '{32'd10, 32'd20, 32'd30012, 32'd10};
        int counts[4] = '{6, 3, 6, 6};
        int lat;
        logic [V-1:0] v;
        logic e;
        for (int k = 0; k < 4; k++) begin
            run_load(bases[k], 3'(counts[k]), lat, v, e);
            nchecks++; if (lat !== model_n(counts[k]) + 1) begin nerr++; $display("FAIL directed%0d latency: got %0d expected %0d", k, lat, model_n(counts[k]) + 1); end
            nchecks++; if (v !== model_vec(bases[k], counts[k])) begin nerr++; $display("FAIL directed%0d vec_out: got %h expected %h", k, v, model_vec(bases[k], counts[k])); end
            nchecks++; if (e !== model_err(bases[k], counts[k])) begin nerr++; $display("FAIL directed%0d err: got %b expected %b", k, e, model_err(bases[k], counts[k])); end
            if (k == 0) begin
                nchecks++; if (v[S-1:0] !== 32'd110) begin nerr++; $display("FAIL directed lane0: got %0d expected 110", v[S-1:0]); end
            end
            finish_load();
        end
    endtask

    task automatic test_stall();
        int lat;
        logic [V-1:0] v;
        logic e;
        run_load(32'd50, 3'd5, lat, v, e);
        for (int k = 0; k < 5; k++) begin
            start = k[0];
            base_addr = $urandom;
            @(negedge clk);
            nchecks++; if (vec_valid !== 1'b1 || vec_out !== v || err !== e) begin nerr++; $display("FAIL stall%0d: got valid %b vec %h err %b expected valid 1 vec %h err %b", k, vec_valid, vec_out, err, v, e); end
        end
        start = 1'b1;
        vec_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vec_ready = 1'b0;
        nchecks++; if (vec_valid !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL handshake: got valid %b busy %b expected 0 0", vec_valid, busy); end
        nchecks++; if (vec_out !== model_vec(32'd50, 5)) begin nerr++; $display("FAIL retained vec_out: got %h expected %h", vec_out, model_vec(32'd50, 5)); end
        @(negedge clk);
        nchecks++; if (busy !== 1'b0) begin nerr++; $display("FAIL start not queued busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [V-1:0] v;
        logic e;
        start = 1'b1;
        base_addr = 32'd40;
        count = 3'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        nchecks++; if (busy !== 1'b1 || rom_addr !== 32'd42) begin nerr++; $display("FAIL midfetch: got busy %b addr %0d expected 1 42", busy, rom_addr); end
        reset = 1'b1;
        #1;
        nchecks++; if (vec_out !== '0 || vec_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || rom_addr !== '0) begin nerr++; $display("FAIL async reset: got vec %h valid %b busy %b err %b addr %h expected all 0", vec_out, vec_valid, busy, err, rom_addr); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_load(32'd0, 3'd0, lat, v, e);
        nchecks++; if (lat !== 7 || v !== model_vec(32'd0, 6) || e !== 1'b0) begin nerr++; $display("FAIL post-reset load: got lat %0d vec %h err %b expected 7 %h 0", lat, v, e, model_vec(32'd0, 6)); end
        finish_load();
    endtask

    task automatic test_wrap();
        int lat;
        logic [V-1:0] v;
        logic e;
        logic [S-1:0] b = 32'hFFFF_FFFE;
        run_load(b, 3'd4, lat, v, e);
        nchecks++; if (seen_addr.size() !== 4) begin nerr++; $display("FAIL wrap addr count: got %0d expected 4", seen_addr.size()); end
        for (int i = 0; i < seen_addr.size() && i < 4; i++) begin
            nchecks++; if (seen_addr[i] !== b + S'(i)) begin nerr++; $display("FAIL wrap addr%0d: got %h expected %h", i, seen_addr[i], b + S'(i)); end
        end
        nchecks++; if (v !== {64'd0, 32'd101, 32'd100, 64'd0}) begin nerr++; $display("FAIL wrap vec_out: got %h expected %h", v, {64'd0, 32'd101, 32'd100, 64'd0}); end
        nchecks++; if (e !== 1'b1) begin nerr++; $display("FAIL wrap err: got %b expected 1", e); end
        finish_load();
    endtask

    task automatic test_random();
        int lat, c, sel;
        logic [V-1:0] v;
        logic e;
        logic [S-1:0] b;
        for (int k = 0; k < 30; k++) begin
            sel = $urandom_range(0, 2);
            b = sel == 0 ? S'($urandom_range(0, 100)) :
                sel == 1 ? S'(SIZE - 8 + $urandom_range(0, 15)) : 32'hFFFF_FFF8 + S'($urandom_range(0, 15));
            c = $urandom_range(0, 7);
            run_load(b, 3'(c), lat, v, e);
            nchecks++; if (lat !== model_n(c) + 1) begin nerr++; $display("FAIL rand%0d latency: got %0d expected %0d", k, lat, model_n(c) + 1); end
            nchecks++; if (v !== model_vec(b, c)) begin nerr++; $display("FAIL rand%0d vec_out: got %h expected %h", k, v, model_vec(b, c)); end
            nchecks++; if (e !== model_err(b, c)) begin nerr++; $display("FAIL rand%0d err: got %b expected %b", k, e, model_err(b, c)); end
            nchecks++; if (seen_addr.size() !== model_n(c) || seen_addr[0] !== b) begin nerr++; $display("FAIL rand%0d addrs: got %0d first %h expected %0d first %h", k, seen_addr.size(), seen_addr[0], model_n(c), b); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            finish_load();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
